score_display: RTL and testbench
================================

SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter DIGITS, default 4: number of seven-segment digits driven (2..8).
REQ-002 Parameter SCORE_W, default 14: score register width; SHALL satisfy 2^SCORE_W > MAX_SCORE.
REQ-003 Parameter MAX_SCORE, default 9999: saturation ceiling; SHALL be at most 10^DIGITS-1.
REQ-004 Parameter SCAN_DIV, default 16: prescaler width; each digit is held 2^SCAN_DIV clocks.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 add_valid  input  1  one-cycle strobe: add add_val to the score.
REQ-008 add_val  input  8  unsigned increment.
REQ-009 clear  input  1  one-cycle strobe: score to 0.
REQ-010 score  output  SCORE_W  current binary score.
REQ-011 bcd_ready  output  1  high when the displayed digits equal the current score.
REQ-012 AN  output  DIGITS  digit enables, active-low, one-hot-low.
REQ-013 SEGMENT  output  8  {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-014 Score update: add_valid sampled at edge N gives score = min(score+add_val, MAX_SCORE) after edge N; the sum SHALL be computed at SCORE_W+1 bits before saturating.
REQ-015 clear SHALL have priority over add_valid in the same cycle; the result is score = 0.
REQ-016 Converter FSM states: IDLE, SHIFT, DONE.
REQ-017 IDLE: if score != src (last converted value), latch src = score, clear the shift register, go to SHIFT; otherwise stay.
REQ-018 SHIFT: one double-dabble step per cycle (add 3 to each nibble >= 5, then shift left 1) for exactly SCORE_W cycles, then go to DONE.
REQ-019 DONE: copy the BCD result into the display register disp_bcd (4*DIGITS bits), return to IDLE.
REQ-020 Latency: disp_bcd SHALL reflect a score change SCORE_W+2 cycles after the score register updates, if the FSM was in IDLE.
REQ-021 A score change during SHIFT SHALL NOT abort the conversion. The converter completes, then IDLE restarts with the new score. The display never shows a partially converted value.
REQ-022 bcd_ready = (state == IDLE) && (score == src).
REQ-023 Scan: the prescaler counts freely. On its wrap, the digit index advances 0..DIGITS-1 and wraps to 0. AN[index] = 0 and all other AN bits = 1.
REQ-024 Digit 0 is the least significant digit.
REQ-025 Segment decode for values 0-9 SHALL be the standard active-low pattern, with dp = 1 (off).
REQ-026 BCD nibble values above 9 SHALL never occur; if one does, SEGMENT = 8'hFF.
REQ-027 Leading-zero blanking: a digit above the most significant nonzero digit SHALL drive SEGMENT = 8'hFF. Digit 0 SHALL always be shown.
REQ-028 AN and SEGMENT SHALL be registered outputs with no combinational path from the inputs.

Reset
REQ-029 rst SHALL force the following values: score = 0, src = 0, disp_bcd = 0, state = IDLE, prescaler = 0, digit index = 0.
REQ-030 On the cycle after rst, the outputs SHALL be: AN = all ones except AN[0] = 0, SEGMENT = the "0" pattern (8'hC0), and bcd_ready = 1.
REQ-031 rst asserted during SHIFT SHALL discard the conversion; add_valid and clear SHALL be ignored while rst is high.

Structure
REQ-032 Shared package score_pkg SHALL hold the seven-segment pattern constants (digits 0-9, SEG_BLANK = 8'hFF) and the FSM state enumeration.
REQ-033 The converter SHALL be a sub-module bin2bcd_seq (start/busy/done handshake, parametrised by SCORE_W and DIGITS). The scan and decode logic SHALL remain in score_display.

Verification
REQ-034 Reset, then hold idle: AN cycles 1110, 1101, 1011, 0111 every 2^SCAN_DIV clocks; digit 0 shows 8'hC0; the other digits show 8'hFF.
REQ-035 add_val = 123 strobed once: score = 123 next cycle; bcd_ready low for 16 cycles; digits read _123 with the top digit blank.
REQ-036 Score 9990, add_val = 200: score saturates to 9999; all four digits show 8'h90.
REQ-037 clear and add_valid (add_val = 5) in the same cycle with score = 40: score = 0; display returns to 0.
REQ-038 Second add (add_val = 7) issued mid-SHIFT after score = 50: display goes 50 then 57; no other value appears on disp_bcd.
REQ-039 rst pulsed mid-SHIFT: all outputs take their REQ-030 values on the next cycle; no stale BCD value is displayed.

Source files
------------

// File: rtl/score_pkg.sv
// Shared definitions for the score display: seven-segment patterns
// (active-low {dp,g,f,e,d,c,b,a}) and the converter FSM states.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Nibble to segment pattern; anything that is not a decimal digit blanks.
  function automatic logic [7:0] seg_of(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter, one bit per clock.
//
//   state | meaning
//   IDLE  | waiting for start; start loads bin and clears the BCD field
//   SHIFT | one add-3/shift-left step per cycle, SCORE_W cycles total
//   DONE  | bcd holds the finished result for one cycle (done = 1)
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int SCORE_W = 14,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SCORE_W-1:0]    bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int SR_W  = 4*DIGITS + SCORE_W;
  localparam int CNT_W = $clog2(SCORE_W + 1);

  conv_state_t       state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [SR_W-1:0]   shreg;
  logic [SR_W-1:0]   shreg_adj;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; the bit counter reaching zero ends the shift phase
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add 3 to every BCD nibble that is 5 or more before the next shift
  always_comb begin
    shreg_adj = shreg;
    for (int i = 0; i < DIGITS; i++) begin
      if (shreg[SCORE_W+4*i +: 4] >= 4'd5)
        shreg_adj[SCORE_W+4*i +: 4] = shreg[SCORE_W+4*i +: 4] + 4'd3;
    end
  end

  // Shift register and down-counting bit timer
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= {{(4*DIGITS){1'b0}}, bin};
            cnt   <= CNT_W'(SCORE_W - 1);
          end
        end
        SHIFT: begin
          shreg <= {shreg_adj[SR_W-2:0], 1'b0};
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign bcd  = shreg[SCORE_W +: 4*DIGITS];

endmodule

// File: rtl/score_display.sv
// Saturating score counter with a multiplexed seven-segment readout.
// The BCD conversion runs in the background; the display register only
// ever takes complete conversion results.
module score_display
  import score_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCORE_W   = 14,
  parameter int MAX_SCORE = 9999,
  parameter int SCAN_DIV  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                add_valid,
  input  logic [7:0]          add_val,
  input  logic                clear,
  output logic [SCORE_W-1:0]  score,
  output logic                bcd_ready,
  output logic [DIGITS-1:0]   AN,
  output logic [7:0]          SEGMENT
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SCORE_W:0]   MAX_WIDE = (SCORE_W+1)'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] MAX_VAL  = SCORE_W'(MAX_SCORE);

  logic [SCORE_W:0]      sum;
  logic [SCORE_W-1:0]    src;
  logic [4*DIGITS-1:0]   disp_bcd;
  logic                  conv_start, conv_busy, conv_done;
  logic [4*DIGITS-1:0]   conv_bcd;
  logic [SCAN_DIV-1:0]   prescaler;
  logic                  scan_tick;
  logic [IDX_W-1:0]      digit_idx;
  logic [IDX_W-1:0]      msd;
  logic [3:0]            nib;
  logic [7:0]            seg_nxt;
  logic [DIGITS-1:0]     an_nxt;
  logic [DIGITS-1:0]     an_q;
  logic [7:0]            seg_q;

  // One extra bit so a sum past the ceiling cannot wrap before saturating
  assign sum = {1'b0, score} + (SCORE_W+1)'(add_val);

  // Score register: clear wins over add; adds saturate at MAX_SCORE
  always_ff @(posedge clk) begin
    if (rst)            score <= '0;
    else if (clear)     score <= '0;
    else if (add_valid) score <= (sum > MAX_WIDE) ? MAX_VAL : sum[SCORE_W-1:0];
  end

  assign conv_start = !conv_busy && (score != src);
  assign bcd_ready  = !conv_busy && (score == src);

  bin2bcd_seq #(
    .SCORE_W (SCORE_W),
    .DIGITS  (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (score),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Remember what is being converted; take the result only when finished
  always_ff @(posedge clk) begin
    if (rst) begin
      src      <= '0;
      disp_bcd <= '0;
    end else begin
      if (conv_start) src <= score;
      if (conv_done)  disp_bcd <= conv_bcd;
    end
  end

  // Free-running down-counting prescaler; terminal count 1 gives a period of 2^SCAN_DIV
  always_ff @(posedge clk) begin
    if (rst) prescaler <= '0;
    else     prescaler <= prescaler - SCAN_DIV'(1);
  end

  assign scan_tick = (prescaler == SCAN_DIV'(1));

  // Digit index steps through 0..DIGITS-1 once per prescaler period
  always_ff @(posedge clk) begin
    if (rst)
      digit_idx <= '0;
    else if (scan_tick)
      digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
  end

  // Select the current nibble, find the top nonzero digit, decode with blanking
  always_comb begin
    msd = '0;
    nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (disp_bcd[4*i +: 4] != 4'd0) msd = IDX_W'(i);
      if (digit_idx == IDX_W'(i))     nib = disp_bcd[4*i +: 4];
    end
    seg_nxt = (digit_idx > msd) ? SEG_BLANK : seg_of(nib);
    an_nxt  = ~(DIGITS'(1) << digit_idx);
  end

  // Registered drive of the anodes and segments
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= ~DIGITS'(1);
      seg_q <= SEG_0;
    end else begin
      an_q  <= an_nxt;
      seg_q <= seg_nxt;
    end
  end

  assign AN      = an_q;
  assign SEGMENT = seg_q;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: the driver keeps a decimal model of the
// score and queues expected values; monitors compare the score after each
// strobe and the scanned display after each conversion settles.
module tb_score_display;

  localparam int DIGITS    = 4;
  localparam int SCORE_W   = 14;
  localparam int MAX_SCORE = 9999;
  localparam int SCAN_DIV  = 3;
  localparam int HOLD      = 1 << SCAN_DIV;
  localparam int SCAN_LEN  = DIGITS * HOLD;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                add_valid = 1'b0;
  logic [7:0]          add_val = 8'd0;
  logic                clear = 1'b0;
  logic [SCORE_W-1:0]  score;
  logic                bcd_ready;
  logic [DIGITS-1:0]   AN;
  logic [7:0]          SEGMENT;

  always #5 clk = ~clk;

  score_display #(
    .DIGITS    (DIGITS),
    .SCORE_W   (SCORE_W),
    .MAX_SCORE (MAX_SCORE),
    .SCAN_DIV  (SCAN_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .add_valid (add_valid),
    .add_val   (add_val),
    .clear     (clear),
    .score     (score),
    .bcd_ready (bcd_ready),
    .AN        (AN),
    .SEGMENT   (SEGMENT)
  );

  int checks = 0;
  int errors = 0;
  int score_q[$];
  int disp_q[$];
  int model = 0;
  int txn_start = 0;
  bit txn_changed = 1'b0;

  function automatic logic [7:0] digit_pattern(input int dg);
    case (dg)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int v, input int d);
    int p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    if (d > 0 && v < p) return 8'hFF;
    return digit_pattern((v / p) % 10);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Watch AN/SEGMENT for ncyc cycles: one-hot-low anode, segment per digit,
  // digit order and per-digit hold time.
  task automatic scan_check(input int value, input int ncyc, input string tag);
    int d;
    int last = -1;
    int run = 0;
    bit first = 1'b1;
    logic [DIGITS-1:0] pat;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      d = -1;
      for (int k = 0; k < DIGITS; k++) begin
        pat = ~(DIGITS'(1) << k);
        if (AN === pat) d = k;
      end
      if (d < 0) begin
        checks++;
        errors++;
        $display("FAIL %s_an_onehot got %b want one-hot-low", tag, AN);
      end else begin
        chk($sformatf("%s_seg_d%0d_v%0d", tag, d, value), SEGMENT, exp_seg(value, d));
        if (last >= 0 && d != last) begin
          chk($sformatf("%s_an_order", tag), d, (last + 1) % DIGITS);
          if (!first) chk($sformatf("%s_hold", tag), run, HOLD);
          first = 1'b0;
          run = 0;
        end
        run++;
        last = d;
      end
    end
  endtask

  // Drive one strobe cycle and update the decimal model
  task automatic strobe(input bit a, input bit c, input int v);
    add_valid = a;
    clear     = c;
    add_val   = 8'(v);
    if (c)      model = 0;
    else if (a) model = (model + v > MAX_SCORE) ? MAX_SCORE : model + v;
    if (a || c) score_q.push_back(model);
    if (model != txn_start) txn_changed = 1'b1;
    @(negedge clk);
    add_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic begin_txn();
    txn_start   = model;
    txn_changed = 1'b0;
  endtask

  task automatic txn_push();
    if (txn_changed) disp_q.push_back(model);
  endtask

  task automatic settle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bcd_ready !== 1'b1 && n < 300);
    chk("ready_timeout", bcd_ready, 1);
    repeat (SCAN_LEN + 8) @(negedge clk);
  endtask

  // Score monitor: after every accepted strobe, compare score with the queue
  initial begin
    logic st;
    int ex;
    forever begin
      @(posedge clk);
      st = !rst && (add_valid || clear);
      @(negedge clk);
      if (st) begin
        if (score_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL score_unexpected got %0d want none", score);
        end else begin
          ex = score_q.pop_front();
          chk("score", score, ex);
        end
      end
    end
  end

  // Display monitor: each rise of bcd_ready presents a converted value
  initial begin
    logic prev = 1'b1;
    int ex;
    forever begin
      @(negedge clk);
      if (prev === 1'b0 && bcd_ready === 1'b1) begin
        if (disp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL disp_unexpected got ready want none");
        end else begin
          ex = disp_q.pop_front();
          @(negedge clk);
          scan_check(ex, SCAN_LEN + 2, "disp");
        end
      end
      prev = bcd_ready;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d;
    int ns;
    int r;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_an", AN, 4'b1110);
    chk("rst_seg", SEGMENT, 8'hC0);
    chk("rst_ready", bcd_ready, 1);
    chk("rst_score", score, 0);
    rst = 1'b0;

    scan_check(0, 2 * SCAN_LEN, "idle");

    // 123 from zero: 16 cycles not ready, display _123
    begin_txn();
    strobe(1'b1, 1'b0, 123);
    txn_push();
    n = 0;
    while (bcd_ready === 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("ready_low_cycles", n, SCORE_W + 2);
    settle();

    // Climb to 9990 with back-to-back adds, then saturate
    begin_txn();
    while (model < 9990) begin
      d = 9990 - model;
      if (d > 255) d = 255;
      strobe(1'b1, 1'b0, d);
    end
    txn_push();
    settle();
    begin_txn();
    strobe(1'b1, 1'b0, 200);
    txn_push();
    settle();

    // Score 40, then clear and add in the same cycle
    begin_txn();
    strobe(1'b0, 1'b1, 0);
    strobe(1'b1, 1'b0, 40);
    txn_push();
    settle();
    begin_txn();
    strobe(1'b1, 1'b1, 5);
    txn_push();
    settle();

    // Second add lands while the first conversion is shifting
    begin_txn();
    strobe(1'b1, 1'b0, 50);
    repeat (3) @(negedge clk);
    strobe(1'b1, 1'b0, 7);
    txn_push();
    settle();

    // Reset mid-conversion, with an add presented during reset
    begin_txn();
    strobe(1'b1, 1'b0, 99);
    repeat (4) @(negedge clk);
    rst       = 1'b1;
    add_valid = 1'b1;
    add_val   = 8'd10;
    disp_q.delete();
    disp_q.push_back(0);
    model = 0;
    @(negedge clk);
    chk("midrst_an", AN, 4'b1110);
    chk("midrst_seg", SEGMENT, 8'hC0);
    chk("midrst_ready", bcd_ready, 1);
    chk("midrst_score", score, 0);
    rst       = 1'b0;
    add_valid = 1'b0;
    settle();

    // Random transactions of one or two strobes
    for (int t = 0; t < 14; t++) begin
      begin_txn();
      ns = $urandom_range(1, 2);
      for (int s = 0; s < ns; s++) begin
        r = $urandom_range(0, 7);
        if (r == 0)      strobe(1'b0, 1'b1, 0);
        else if (r == 1) strobe(1'b1, 1'b1, $urandom_range(0, 255));
        else             strobe(1'b1, 1'b0, $urandom_range(0, 255));
        if (s < ns - 1) repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      txn_push();
      settle();
    end

    chk("score_q_drained", score_q.size(), 0);
    chk("disp_q_drained", disp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
